// File: rtl/axi_fork_if.sv
// Stream bundle for axi_fork: one input stream and SIZE output streams.
// The fork itself uses the slave modport; the stream source/sink side uses master.
interface axi_fork_if #(
    parameter int unsigned SIZE  = 2,
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0]      i_tdata;
    logic                  i_tlast;
    logic                  i_tvalid;
    logic                  i_tready;
    logic [WIDTH*SIZE-1:0] o_tdata;
    logic [SIZE-1:0]       o_tlast;
    logic [SIZE-1:0]       o_tvalid;
    logic [SIZE-1:0]       o_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/axi_fork.sv
// One-beat stream fork: a single holding register fans out to SIZE ports,
// each port draining independently; the port mask is latched per packet.
module axi_fork #(
    parameter int unsigned SIZE  = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic [SIZE-1:0] port_en,
    axi_fork_if.slave       s
);
    logic             hold_v_q, hold_v_d;
    logic [SIZE-1:0]  pend_q,   pend_d;
    logic [SIZE-1:0]  mask_q,   mask_d;
    logic             sop_q,    sop_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             last_q,   last_d;

    logic [SIZE-1:0]  take;
    logic [SIZE-1:0]  active;
    logic             free;
    logic             accept;

    // The register frees when no pending port is still refusing the beat.
    always_comb begin
        take   = pend_q & s.o_tready & {SIZE{hold_v_q}};
        free   = !hold_v_q || ((pend_q & ~s.o_tready) == '0);
        active = sop_q ? port_en : mask_q;
    end

    assign s.i_tready = reset_n & ~clear & free;
    assign accept     = s.i_tvalid & s.i_tready;

    assign s.o_tvalid = pend_q & {SIZE{hold_v_q}};
    assign s.o_tlast  = {SIZE{last_q}};
    assign s.o_tdata  = {SIZE{data_q}};

    always_comb begin
        hold_v_d = hold_v_q;
        pend_d   = pend_q & ~take;
        mask_d   = mask_q;
        sop_d    = sop_q;
        data_d   = data_q;
        last_d   = last_q;
        if (clear) begin
            hold_v_d = 1'b0;
            pend_d   = '0;
            mask_d   = '0;
            sop_d    = 1'b1;
            data_d   = '0;
            last_d   = 1'b0;
        end else if (accept) begin
            // A zero active mask loads nothing pending, so the beat is discarded.
            data_d   = s.i_tdata;
            last_d   = s.i_tlast;
            pend_d   = active;
            mask_d   = active;
            hold_v_d = |active;
            sop_d    = s.i_tlast;
        end else if (free) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_v_q <= 1'b0;
            pend_q   <= '0;
            mask_q   <= '0;
            sop_q    <= 1'b1;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            hold_v_q <= hold_v_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            sop_q    <= sop_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end
endmodule
